// File: rtl/game_ctrl.sv
// game_ctrl: game-flow controller for the slime game.
// Tracks IDLE/PLAY/HURT/OVER, lives, the invulnerability timer after a
// ceiling hit, a saturating three-digit BCD floor score, and a game-over pulse.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | power-up / reset, waiting for key_start
// PLAY  | normal play, ceiling hits and falls are checked
// HURT  | invulnerable after a hit, counts down INVULN_TICKS frames
// OVER  | game over, lives and score held until key_start
module game_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int INVULN_TICKS = 60,
    parameter int FALL_Y       = 470
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        key_start,
    input  logic        hit_ceiling,
    input  logic [9:0]  slime_y,
    input  logic        floor_landed,
    output logic [1:0]  state,
    output logic        run,
    output logic        flash,
    output logic [1:0]  lives,
    output logic [11:0] score_bcd,
    output logic        over_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HURT = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] score_q, score_d;
    logic        run_q, run_d;
    logic        flash_q, flash_d;
    logic        over_q, over_d;
    logic        fall;
    logic        active;

    // BCD +1 with ones->tens->hundreds carry; the caller handles saturation at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h, t, o;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

    // Next-state, lives, timer, score and registered-output computation.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        fall    = (slime_y >= 10'(FALL_Y));
        active  = (state_q == PLAY) || (state_q == HURT);

        case (state_q)
            IDLE, OVER: begin
                if (key_start) begin
                    state_d = PLAY;
                    lives_d = 2'(LIVES_INIT);
                    score_d = 12'h000;
                    cnt_d   = 8'd0;
                end
            end
            PLAY: begin
                if (fall) begin
                    state_d = OVER;
                    lives_d = 2'd0;
                end else if (hit_ceiling) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q <= 2'd1) begin
                        state_d = OVER;
                        lives_d = 2'd0;
                    end else begin
                        state_d = HURT;
                        cnt_d   = 8'(INVULN_TICKS);
                    end
                end
            end
            HURT: begin
                // hit_ceiling is masked here; only a fall or the timer leaves HURT.
                if (fall) begin
                    state_d = OVER;
                    lives_d = 2'd0;
                    cnt_d   = 8'd0;
                end else if (tick) begin
                    if (cnt_q <= 8'd1) begin
                        state_d = PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Landing counts whenever the current state is active, even on a death edge.
        if (active && floor_landed && (score_q != 12'h999)) begin
            score_d = bcd_inc(score_q);
        end

        run_d   = (state_d == PLAY) || (state_d == HURT);
        flash_d = (state_d == HURT) && cnt_d[2];
        over_d  = (state_d == OVER) && (state_q != OVER);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            lives_q <= 2'd0;
            cnt_q   <= 8'd0;
            score_q <= 12'h000;
            run_q   <= 1'b0;
            flash_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            run_q   <= run_d;
            flash_q <= flash_d;
            over_q  <= over_d;
        end
    end

    assign state      = state_q;
    assign run        = run_q;
    assign flash      = flash_q;
    assign lives      = lives_q;
    assign score_bcd  = score_q;
    assign over_pulse = over_q;

endmodule
